alu_md_ctrl: RTL and testbench

// Registered ALU-control decoder with an iterative multiply/divide sequencer and HI/LO registers.

---
 rtl/alu_md_ctrl_if.sv | 19 +
 rtl/alu_md_ctrl.sv | 119 +++++++++++
 tb/tb_alu_md_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_md_ctrl_if.sv
// alu_md_ctrl_if: issue/decode/write-back bundle between control unit, alu_md_ctrl and the write-back mux
interface alu_md_ctrl_if #(parameter int WIDTH = 32, parameter int CTRL_W = 4);
  logic valid_in;
  logic [3:0] aluop;
  logic [WIDTH-1:0] instr, src_a, src_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic ctrl_valid;
  logic [1:0] rd_sel;
  logic illegal, stall, md_busy, md_done, div_zero;
  logic [WIDTH-1:0] hi, lo;
  modport master (
    output valid_in, aluop, instr, src_a, src_b,
    input alu_ctrl, ctrl_valid, rd_sel, illegal, stall, md_busy, md_done, div_zero, hi, lo
  );
  modport slave (
    input valid_in, aluop, instr, src_a, src_b,
    output alu_ctrl, ctrl_valid, rd_sel, illegal, stall, md_busy, md_done, div_zero, hi, lo
  );
endinterface

// File: rtl/alu_md_ctrl.sv
// alu_md_ctrl: registered ALU-control decoder with iterative mult/div sequencer and HI/LO registers
module alu_md_ctrl #(
  parameter int WIDTH = 32,
  parameter int CTRL_W = 4
) (
  input logic clk,
  input logic rst,
  alu_md_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m, ra;
  logic sa, sb, is_div, bz;
  logic [5:0] funct;
  logic [3:0] code;
  logic [1:0] rsel;
  logic ill, is_md, accept, start, ld_sa, ld_sb;
  logic [WIDTH:0] sum, t;
  logic [WIDTH-1:0] diff, quo, rem;
  logic ge;
  logic [2*WIDTH-1:0] prod;
  assign funct = bus.instr[5:0];
  always_comb begin
    code = '0;
    rsel = '0;
    ill = 1'b0;
    is_md = 1'b0;
    case (bus.aluop)
      4'h1: code = 4'd1;
      4'h3: code = 4'd2;
      4'h4: code = 4'd3;
      4'h5: code = 4'd8;
      4'h6: code = 4'd9;
      4'h7: code = 4'd10;
      4'h8: code = 4'd11;
      4'h9: code = 4'd12;
      4'hA: code = 4'd13;
      4'h2: begin
        if (funct < 6'h08 || funct == 6'h0E || funct == 6'h0F) code = funct[3:0];
        else if (funct == 6'h10) rsel = 2'b01;
        else if (funct == 6'h12) rsel = 2'b10;
        else if (funct[5:2] == 4'b0110) is_md = 1'b1;
        else ill = 1'b1;
      end
      default: code = '0;
    endcase
  end
  assign bus.md_busy = state != IDLE;
  assign bus.stall = bus.valid_in & bus.md_busy & (is_md | (|rsel));
  assign accept = bus.valid_in & ~bus.stall;
  assign start = accept & is_md;
  // even funct codes (mult, div) are the signed variants
  assign ld_sa = ~funct[0] & bus.src_a[WIDTH-1];
  assign ld_sb = ~funct[0] & bus.src_b[WIDTH-1];
  always_comb begin
    nxt = state == IDLE ? (start ? RUN : IDLE) :
          state == RUN ? (cnt == CW'(WIDTH - 1) ? FIX : RUN) : IDLE;
  end
  // multiply: {acc,q} shifts right while adding m; divide: restoring, remainder in acc
  assign sum = {1'b0, acc} + {1'b0, q[0] ? m : '0};
  assign t = {acc, q[WIDTH-1]};
  assign ge = t >= {1'b0, m};
  assign diff = t[WIDTH-1:0] - m;
  assign prod = (sa ^ sb) ? -{acc, q} : {acc, q};
  assign quo = (sa ^ sb) ? -q : q;
  assign rem = sa ? -acc : acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      q <= '0;
      m <= '0;
      ra <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      is_div <= 1'b0;
      bz <= 1'b0;
      bus.alu_ctrl <= '0;
      bus.ctrl_valid <= 1'b0;
      bus.rd_sel <= '0;
      bus.illegal <= 1'b0;
      bus.md_done <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
    end else begin
      state <= nxt;
      bus.ctrl_valid <= accept;
      if (accept) begin
        bus.alu_ctrl <= CTRL_W'(code);
        bus.rd_sel <= rsel;
        bus.illegal <= ill;
      end
      bus.md_done <= state == FIX;
      bus.div_zero <= state == FIX && is_div && bz;
      if (state == IDLE && start) begin
        cnt <= '0;
        acc <= '0;
        q <= ld_sa ? -bus.src_a : bus.src_a;
        m <= ld_sb ? -bus.src_b : bus.src_b;
        ra <= bus.src_a;
        sa <= ld_sa;
        sb <= ld_sb;
        is_div <= funct[1];
        bz <= bus.src_b == '0;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
        acc <= is_div ? (ge ? diff : t[WIDTH-1:0]) : sum[WIDTH:1];
        q <= is_div ? {q[WIDTH-2:0], ge} : {sum[0], q[WIDTH-1:1]};
      end else if (state == FIX) begin
        bus.hi <= is_div ? (bz ? ra : rem) : prod[2*WIDTH-1:WIDTH];
        bus.lo <= is_div ? (bz ? '1 : quo) : prod[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_alu_md_ctrl.sv
// tb_alu_md_ctrl: randomized decode and mult/div checks against a behavioural model
module tb_alu_md_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  localparam int AMAP [16] = '{0, 1, -1, 2, 3, 8, 9, 10, 11, 12, 13, -2, -2, -2, -2, -2};
  alu_md_ctrl_if #(.WIDTH(32), .CTRL_W(4)) bus ();
  alu_md_ctrl #(.WIDTH(32), .CTRL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input bit v, input logic [3:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = $urandom();
    r[5:0] = f;
    bus.valid_in = v;
    bus.aluop = op;
    bus.instr = r;
    bus.src_a = a;
    bus.src_b = b;
  endtask
  function automatic void dec(input logic [3:0] op, input logic [5:0] f, output logic [3:0] code,
                              output logic [1:0] rsel, output logic ill, output logic md);
    code = 0;
    rsel = 0;
    ill = 0;
    md = 0;
    if (AMAP[op] >= 0) code = 4'(AMAP[op]);
    else if (op == 4'd2) begin
      if (f inside {[0:7], 14, 15}) code = f[3:0];
      else if (f == 6'h10) rsel = 2'b01;
      else if (f == 6'h12) rsel = 2'b10;
      else if (f inside {[6'h18:6'h1B]}) md = 1;
      else ill = 1;
    end
  endfunction
  function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] p;
    longint x, y, qq, rr;
    dz = 0;
    if (f == 6'h18) p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else if (f == 6'h19) p = {32'b0, a} * {32'b0, b};
    else if (b == 0) begin
      p = {a, 32'hFFFF_FFFF};
      dz = 1;
    end else begin
      x = (f == 6'h1A) ? longint'($signed(a)) : longint'({32'b0, a});
      y = (f == 6'h1A) ? longint'($signed(b)) : longint'({32'b0, b});
      qq = x / y;
      rr = x % y;
      p = {rr[31:0], qq[31:0]};
    end
    hi = p[63:32];
    lo = p[31:0];
  endfunction
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit probe);
    logic [31:0] ehi, elo;
    logic edz;
    int k;
    md_model(f, a, b, ehi, elo, edz);
    drive(1, 4'd2, f, a, b);
    #1 chk("md_issue_stall", bus.stall, 0);
    @(posedge clk);
    #1;
    chk("md_cv", bus.ctrl_valid, 1);
    chk("md_code", bus.alu_ctrl, 0);
    chk("md_rsel", bus.rd_sel, 0);
    chk("md_busy", bus.md_busy, 1);
    for (k = 1; k <= 40; k++) begin
      if (probe && k == 1) begin
        drive(1, 4'd2, 6'h12, 0, 0);
        #1 chk("mflo_stall", bus.stall, 1);
      end else if (probe && k == 2) begin
        drive(1, 4'd1, 6'h00, 0, 0);
        #1 chk("nonmd_stall", bus.stall, 0);
      end else bus.valid_in = 0;
      @(posedge clk);
      #1;
      if (probe && k == 1) chk("mflo_cv", bus.ctrl_valid, 0);
      if (probe && k == 2) begin
        chk("busy_alu_cv", bus.ctrl_valid, 1);
        chk("busy_alu_code", bus.alu_ctrl, 1);
      end
      if (bus.md_done) break;
    end
    chk("md_latency", k, 33);
    chk("md_hi", bus.hi, ehi);
    chk("md_lo", bus.lo, elo);
    chk("md_dz", bus.div_zero, edz);
    chk("md_idle", bus.md_busy, 0);
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [3:0] ec, c;
    logic [1:0] er, r;
    logic ei, il, md, v;
    logic [3:0] op;
    logic [5:0] f;
    int seen;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", bus.alu_ctrl, 0);
    chk("rst_cv", bus.ctrl_valid, 0);
    chk("rst_rsel", bus.rd_sel, 0);
    chk("rst_ill", bus.illegal, 0);
    chk("rst_busy", bus.md_busy, 0);
    chk("rst_done", bus.md_done, 0);
    chk("rst_hilo", {bus.hi, bus.lo}, 0);
    rst = 0;
    ec = 0;
    er = 0;
    ei = 0;
    for (int i = 0; i < 230; i++) begin
      if (i < 64) begin
        op = 4'd2;
        f = 6'(i);
        v = 1;
      end else begin
        op = 4'($urandom());
        f = 6'($urandom());
        v = $urandom_range(0, 3) != 0;
      end
      dec(op, f, c, r, il, md);
      if (md) begin
        f = 6'h08;
        dec(op, f, c, r, il, md);
      end
      drive(v, op, f, $urandom(), $urandom());
      #1 chk("dec_stall", bus.stall, 0);
      @(posedge clk);
      #1;
      if (v) begin
        ec = c;
        er = r;
        ei = il;
      end
      chk("dec_cv", bus.ctrl_valid, v);
      chk("dec_code", bus.alu_ctrl, ec);
      chk("dec_rsel", bus.rd_sel, er);
      chk("dec_ill", bus.illegal, ei);
    end
    run_md(6'h18, 7, 32'hFFFF_FFFD, 1);
    run_md(6'h1B, 100, 7, 0);
    run_md(6'h1A, 32'hFFFF_FFF9, 2, 0);
    run_md(6'h1A, 5, 0, 0);
    run_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md(6'h1B, 9, 0, 0);
    run_md(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    for (int i = 0; i < 24; i++)
      run_md(6'(6'h18 + $urandom_range(0, 3)), pick(), pick(), i % 6 == 0);
    drive(1, 4'd2, 6'h18, 5, 6);
    @(posedge clk);
    #1 bus.valid_in = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.md_busy, 0);
    chk("abort_hilo", {bus.hi, bus.lo}, 0);
    chk("abort_done", bus.md_done, 0);
    rst = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.md_done) seen++;
    end
    chk("abort_no_done", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
